// File: rtl/bcp_host_driver.sv
// bcp_host_driver: issues one BCP command register image, completes the opcode handshake, returns status; optional watchdog via BCP_DRV_TIMEOUT_EN.
module bcp_host_driver #(
  parameter int VARIABLE_ENCODING_LEN = 5,
  parameter int CLAUSE_ID_LEN = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic [1:0]                         cmd_op_i,
  input  logic [CLAUSE_ID_LEN-1:0]           cmd_clause_id_i,
  input  logic [3*VARIABLE_ENCODING_LEN-1:0] cmd_var_ids_i,
  input  logic [2:0]                         cmd_var_pols_i,
  output logic [31:0]                        axi_reg0_o,
  output logic [31:0]                        axi_reg1_o,
  output logic [31:0]                        axi_reg2_o,
  output logic [31:0]                        axi_reg3_o,
  input  logic                               op_read_i,
  input  logic [31:0]                        status_i,
  input  logic [VARIABLE_ENCODING_LEN:0]     implication_i,
  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [2:0]                         rsp_status_o,
  output logic                               rsp_fresh_o,
  output logic [VARIABLE_ENCODING_LEN:0]     rsp_impl_o
);
  localparam int V = VARIABLE_ENCODING_LEN;
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESPOND} state_t;
  state_t state, state_n;
  logic [31:0] r0_n, r1_n, r2_n, r3_n, snap, snap_n;
  logic [2:0] st_n;
  logic fr_n;
  logic [V:0] im_n;
  function automatic logic [31:0] lit(input logic pol, input logic [V-1:0] id);
    lit = '0;
    lit[0] = pol;
    lit[1+:V] = id;
  endfunction
`ifdef BCP_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt;
`endif
  always_comb begin
    state_n = state;
    r0_n = axi_reg0_o;
    r1_n = axi_reg1_o;
    r2_n = axi_reg2_o;
    r3_n = axi_reg3_o;
    snap_n = snap;
    st_n = rsp_status_o;
    fr_n = rsp_fresh_o;
    im_n = rsp_impl_o;
    case (state)
      IDLE: if (cmd_valid_i && cmd_ready_o) begin
        snap_n = status_i;
        state_n = (cmd_op_i == 2'b00) ? RESPOND : ISSUE;
        if (cmd_op_i != 2'b00) begin
          r0_n = '0;
          r0_n[1:0] = cmd_op_i;
          r0_n[2+:CLAUSE_ID_LEN] = cmd_clause_id_i;
          r1_n = lit(cmd_var_pols_i[0], cmd_var_ids_i[0+:V]);
          r2_n = lit(cmd_var_pols_i[1], cmd_var_ids_i[V+:V]);
          r3_n = lit(cmd_var_pols_i[2], cmd_var_ids_i[2*V+:V]);
        end else begin
          st_n = status_i[2:0];
          fr_n = 1'b0;
          im_n = implication_i;
        end
      end
      ISSUE: if (op_read_i) begin
        state_n = RELEASE;
        r0_n[1:0] = 2'b00;
      end
      RELEASE: if (!op_read_i) begin
        state_n = RESPOND;
        st_n = status_i[2:0];
        fr_n = status_i != snap;
        im_n = implication_i;
      end
      default: if (rsp_ready_i) begin
        state_n = IDLE;
        {r0_n, r1_n, r2_n, r3_n} = '0;
      end
    endcase
`ifdef BCP_DRV_TIMEOUT_EN
    if ((state == ISSUE || state == RELEASE) && state_n == state && cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = RESPOND;
      r0_n[1:0] = 2'b00;
      st_n = 3'b111;
      fr_n = 1'b0;
      im_n = '0;
    end
`endif
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      {axi_reg0_o, axi_reg1_o, axi_reg2_o, axi_reg3_o, snap} <= '0;
      {cmd_ready_o, rsp_valid_o, rsp_status_o, rsp_fresh_o, rsp_impl_o} <= '0;
    end else begin
      state <= state_n;
      axi_reg0_o <= r0_n;
      axi_reg1_o <= r1_n;
      axi_reg2_o <= r2_n;
      axi_reg3_o <= r3_n;
      snap <= snap_n;
      cmd_ready_o <= state_n == IDLE;
      rsp_valid_o <= state_n == RESPOND;
      rsp_status_o <= st_n;
      rsp_fresh_o <= fr_n;
      rsp_impl_o <= im_n;
    end
  end
`ifdef BCP_DRV_TIMEOUT_EN
  always_ff @(posedge clk_i) cnt <= (rst_i || state_n != state) ? '0 : cnt + 1'b1;
`endif
endmodule
